// File: rtl/regfile_sb.sv
// Parametrised integer register file with post-reset clearing sweep,
// same-cycle write bypass and a per-register busy scoreboard.
module regfile_sb #(
    parameter  int unsigned XLEN     = 32,
    parameter  int unsigned DEPTH    = 32,
    parameter  int unsigned NUM_RD   = 2,
    parameter  int unsigned NUM_WR   = 1,
    parameter  int unsigned ZERO_REG = 1,
    localparam int unsigned AW       = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     hold,
    output logic                     init_done,
    input  logic [NUM_RD*AW-1:0]     rd_addr,
    output logic [NUM_RD*XLEN-1:0]   rd_data,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic [NUM_WR-1:0]        wr_en,
    input  logic [NUM_WR*AW-1:0]     wr_addr,
    input  logic [NUM_WR*XLEN-1:0]   wr_data,
    input  logic                     iss_en,
    input  logic [AW-1:0]            iss_addr,
    output logic [AW:0]              pend_cnt
);

    localparam int unsigned CW = AW + 1;

    typedef enum logic {
        ST_CLEAR,
        ST_RUN
    } state_e;

    state_e            state_q, state_d;
    logic [AW-1:0]     clr_idx_q, clr_idx_d;
    logic              init_done_q, init_done_d;
    logic [DEPTH-1:0]  busy_q, busy_d;
    logic [CW-1:0]     pend_cnt_q, pend_cnt_d;
    logic [XLEN-1:0]   mem_q [DEPTH];
    logic [XLEN-1:0]   mem_d [DEPTH];

    logic [AW-1:0]     ra [NUM_RD];
    logic [AW-1:0]     wa [NUM_WR];
    logic [XLEN-1:0]   wd [NUM_WR];
    logic [NUM_WR-1:0] commit;
    logic              set_req;
    logic [DEPTH-1:0]  clr_vec;
    logic [DEPTH-1:0]  set_vec;
    logic              run;

    assign run = (state_q == ST_RUN);

    always_comb begin
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            ra[p] = rd_addr[p*AW +: AW];
        end
        for (int unsigned w = 0; w < NUM_WR; w++) begin
            wa[w] = wr_addr[w*AW +: AW];
            wd[w] = wr_data[w*XLEN +: XLEN];
        end
    end

    // Qualified write commits and issue request; nothing takes effect during the sweep.
    always_comb begin
        for (int unsigned w = 0; w < NUM_WR; w++) begin
            commit[w] = run & wr_en[w] & ~hold & ~((ZERO_REG != 0) && (wa[w] == '0));
        end
        set_req = run & iss_en & ~hold & ~((ZERO_REG != 0) && (iss_addr == '0));
    end

    always_comb begin
        clr_vec = '0;
        set_vec = '0;
        for (int unsigned a = 0; a < DEPTH; a++) begin
            for (int unsigned w = 0; w < NUM_WR; w++) begin
                if (commit[w] && (wa[w] == AW'(a))) begin
                    clr_vec[a] = 1'b1;
                end
            end
            set_vec[a] = set_req && (iss_addr == AW'(a));
        end
    end

    // Scoreboard next state; set beats clear on the same address.
    always_comb begin
        logic [CW-1:0] dec;
        logic          inc;
        dec = '0;
        for (int unsigned a = 0; a < DEPTH; a++) begin
            busy_d[a] = set_vec[a] | (busy_q[a] & ~clr_vec[a]);
            dec       = dec + CW'(busy_q[a] & clr_vec[a] & ~set_vec[a]);
        end
        inc        = set_req & ~busy_q[iss_addr];
        pend_cnt_d = pend_cnt_q + CW'(inc) - dec;
    end

    always_comb begin
        state_d     = state_q;
        clr_idx_d   = clr_idx_q;
        init_done_d = init_done_q;
        if (state_q == ST_CLEAR) begin
            clr_idx_d = clr_idx_q + 1'b1;
            if (clr_idx_q == AW'(DEPTH - 1)) begin
                state_d     = ST_RUN;
                init_done_d = 1'b1;
            end
        end
    end

    // Array update: sweep writes zero; otherwise ports in ascending order so the highest wins.
    always_comb begin
        mem_d = mem_q;
        if (state_q == ST_CLEAR) begin
            mem_d[clr_idx_q] = '0;
        end else begin
            for (int unsigned w = 0; w < NUM_WR; w++) begin
                if (commit[w]) begin
                    mem_d[wa[w]] = wd[w];
                end
            end
        end
    end

    always_comb begin
        for (int unsigned p = 0; p < NUM_RD; p++) begin
            logic [XLEN-1:0] val;
            val = mem_q[ra[p]];
            for (int unsigned w = 0; w < NUM_WR; w++) begin
                if (commit[w] && (wa[w] == ra[p])) begin
                    val = wd[w];
                end
            end
            if (!run || ((ZERO_REG != 0) && (ra[p] == '0))) begin
                val = '0;
            end
            rd_data[p*XLEN +: XLEN] = val;
            rd_busy[p] = run & busy_q[ra[p]] & ~(clr_vec[ra[p]] & ~set_vec[ra[p]]);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_CLEAR;
            clr_idx_q   <= '0;
            init_done_q <= 1'b0;
            busy_q      <= '0;
            pend_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            clr_idx_q   <= clr_idx_d;
            init_done_q <= init_done_d;
            busy_q      <= busy_d;
            pend_cnt_q  <= pend_cnt_d;
        end
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign init_done = init_done_q;
    assign pend_cnt  = pend_cnt_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb (DEPTH=32, two read and two write ports).
module tb_regfile_sb;

    localparam int unsigned XLEN   = 32;
    localparam int unsigned DEPTH  = 32;
    localparam int unsigned NUM_RD = 2;
    localparam int unsigned NUM_WR = 2;
    localparam int unsigned AW     = 5;

    logic                   clk;
    logic                   rst_n;
    logic                   hold;
    logic                   init_done;
    logic [NUM_RD*AW-1:0]   rd_addr;
    logic [NUM_RD*XLEN-1:0] rd_data;
    logic [NUM_RD-1:0]      rd_busy;
    logic [NUM_WR-1:0]      wr_en;
    logic [NUM_WR*AW-1:0]   wr_addr;
    logic [NUM_WR*XLEN-1:0] wr_data;
    logic                   iss_en;
    logic [AW-1:0]          iss_addr;
    logic [AW:0]            pend_cnt;

    int checks;
    int failures;

    regfile_sb #(
        .XLEN    (XLEN),
        .DEPTH   (DEPTH),
        .NUM_RD  (NUM_RD),
        .NUM_WR  (NUM_WR),
        .ZERO_REG(1)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .hold     (hold),
        .init_done(init_done),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .pend_cnt (pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_rd(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic set_wr(input int w, input logic en, input logic [AW-1:0] a, input logic [XLEN-1:0] d);
        wr_en[w]               = en;
        wr_addr[w*AW +: AW]    = a;
        wr_data[w*XLEN +: XLEN] = d;
    endtask

    task automatic idle();
        hold    = 1'b0;
        wr_en   = '0;
        wr_addr = '0;
        wr_data = '0;
        iss_en  = 1'b0;
        iss_addr = '0;
    endtask

    function automatic logic [XLEN-1:0] rdd(input int p);
        return rd_data[p*XLEN +: XLEN];
    endfunction

    task automatic test_reset();
        idle();
        rd_addr = '0;
        rst_n = 1'b0;
        #1;
        checks++;
        if (init_done !== 1'b0) begin failures++; $display("FAIL reset_init_done got=%0b exp=0", init_done); end
        checks++;
        if (pend_cnt !== '0) begin failures++; $display("FAIL reset_pend_cnt got=%0d exp=0", pend_cnt); end
        repeat (3) step();
        @(negedge clk);
        rst_n = 1'b1;
        // Inputs that must be ignored during the sweep; hold must not stall it.
        hold = 1'b1;
        iss_en = 1'b1; iss_addr = 5'd3;
        set_wr(0, 1'b1, 5'd5, 32'hFFFF_0000);
        set_rd(0, 5'd5);
        set_rd(1, 5'd3);
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (init_done !== 1'b0 || rd_data !== '0 || rd_busy !== '0) begin
                failures++;
                $display("FAIL sweep_cycle%0d init_done=%0b rd_data=%h rd_busy=%b exp 0/0/0", i, init_done, rd_data, rd_busy);
            end
            if (i == DEPTH - 1) hold = 1'b0;
            step();
        end
        idle();
        #1;
        checks++;
        if (init_done !== 1'b1) begin failures++; $display("FAIL sweep_done got=%0b exp=1", init_done); end
        checks++;
        if (pend_cnt !== '0) begin failures++; $display("FAIL sweep_pend got=%0d exp=0", pend_cnt); end
        checks++;
        if (rdd(0) !== 32'h0 || rd_busy !== 2'b00) begin
            failures++; $display("FAIL sweep_x5 got=%h busy=%b exp=0 busy=00", rdd(0), rd_busy);
        end
    endtask

    task automatic test_write_read();
        set_wr(0, 1'b1, 5'd5, 32'hDEAD_BEEF);
        step();
        idle();
        set_rd(0, 5'd5);
        #1;
        checks++;
        if (rdd(0) !== 32'hDEAD_BEEF) begin failures++; $display("FAIL wr_x5 got=%h exp=deadbeef", rdd(0)); end
        set_wr(0, 1'b1, 5'd0, 32'h0000_1234);
        set_rd(1, 5'd0);
        #1;
        checks++;
        if (rdd(1) !== 32'h0) begin failures++; $display("FAIL x0_bypass got=%h exp=0", rdd(1)); end
        step();
        idle();
        #1;
        checks++;
        if (rdd(1) !== 32'h0) begin failures++; $display("FAIL x0_after got=%h exp=0", rdd(1)); end
    endtask

    task automatic test_bypass();
        set_wr(0, 1'b1, 5'd7, 32'hA5A5_A5A5);
        set_rd(1, 5'd7);
        #1;
        checks++;
        if (rdd(1) !== 32'hA5A5_A5A5) begin failures++; $display("FAIL bypass got=%h exp=a5a5a5a5", rdd(1)); end
        step();
        hold = 1'b1;
        set_wr(0, 1'b1, 5'd7, 32'h5A5A_5A5A);
        #1;
        checks++;
        if (rdd(1) !== 32'hA5A5_A5A5) begin failures++; $display("FAIL hold_bypass got=%h exp=a5a5a5a5", rdd(1)); end
        step();
        idle();
        #1;
        checks++;
        if (rdd(1) !== 32'hA5A5_A5A5) begin failures++; $display("FAIL hold_nocommit got=%h exp=a5a5a5a5", rdd(1)); end
    endtask

    task automatic test_dual_write();
        set_wr(0, 1'b1, 5'd9, 32'h11);
        set_wr(1, 1'b1, 5'd9, 32'h22);
        set_rd(0, 5'd9);
        #1;
        checks++;
        if (rdd(0) !== 32'h22) begin failures++; $display("FAIL dual_comb got=%h exp=22", rdd(0)); end
        step();
        idle();
        #1;
        checks++;
        if (rdd(0) !== 32'h22) begin failures++; $display("FAIL dual_after got=%h exp=22", rdd(0)); end
    endtask

    task automatic test_back_to_back();
        set_wr(0, 1'b1, 5'd1, 32'h1111_0001);
        step();
        set_wr(0, 1'b1, 5'd2, 32'h2222_0002);
        set_rd(0, 5'd1);
        set_rd(1, 5'd2);
        #1;
        checks++;
        if (rdd(0) !== 32'h1111_0001 || rdd(1) !== 32'h2222_0002) begin
            failures++; $display("FAIL b2b got=%h,%h exp=11110001,22220002", rdd(0), rdd(1));
        end
        step();
        idle();
    endtask

    task automatic test_scoreboard();
        iss_en = 1'b1; iss_addr = 5'd3;
        set_rd(0, 5'd3);
        #1;
        checks++;
        if (rd_busy[0] !== 1'b0) begin failures++; $display("FAIL iss_not_yet got=%0b exp=0", rd_busy[0]); end
        step();
        checks++;
        if (rd_busy[0] !== 1'b1 || pend_cnt !== 6'd1) begin
            failures++; $display("FAIL iss_x3 busy=%0b pend=%0d exp 1/1", rd_busy[0], pend_cnt);
        end
        step();
        checks++;
        if (pend_cnt !== 6'd1) begin failures++; $display("FAIL reissue_x3 got=%0d exp=1", pend_cnt); end
        iss_addr = 5'd4;
        step();
        checks++;
        if (pend_cnt !== 6'd2) begin failures++; $display("FAIL iss_x4 got=%0d exp=2", pend_cnt); end
        iss_en = 1'b0;
        set_wr(0, 1'b1, 5'd3, 32'h33);
        #1;
        checks++;
        if (rd_busy[0] !== 1'b0 || rdd(0) !== 32'h33) begin
            failures++; $display("FAIL wb_x3 busy=%0b data=%h exp 0/33", rd_busy[0], rdd(0));
        end
        step();
        idle();
        #1;
        checks++;
        if (pend_cnt !== 6'd1 || rd_busy[0] !== 1'b0) begin
            failures++; $display("FAIL wb_x3_after pend=%0d busy=%0b exp 1/0", pend_cnt, rd_busy[0]);
        end
        iss_en = 1'b1; iss_addr = 5'd4;
        set_wr(0, 1'b1, 5'd4, 32'h44);
        set_rd(1, 5'd4);
        #1;
        checks++;
        if (rd_busy[1] !== 1'b1) begin failures++; $display("FAIL setclr_comb got=%0b exp=1", rd_busy[1]); end
        step();
        idle();
        #1;
        checks++;
        if (rd_busy[1] !== 1'b1 || pend_cnt !== 6'd1) begin
            failures++; $display("FAIL setclr_after busy=%0b pend=%0d exp 1/1", rd_busy[1], pend_cnt);
        end
        iss_en = 1'b1; iss_addr = 5'd0;
        step();
        iss_addr = 5'd6; hold = 1'b1;
        step();
        idle();
        set_wr(0, 1'b1, 5'd10, 32'hA);
        step();
        idle();
        checks++;
        if (pend_cnt !== 6'd1) begin failures++; $display("FAIL ignored_sets got=%0d exp=1", pend_cnt); end
        iss_en = 1'b1; iss_addr = 5'd11;
        step();
        iss_addr = 5'd12;
        step();
        idle();
        checks++;
        if (pend_cnt !== 6'd3) begin failures++; $display("FAIL two_more got=%0d exp=3", pend_cnt); end
        set_wr(0, 1'b1, 5'd11, 32'hB);
        set_wr(1, 1'b1, 5'd12, 32'hC);
        set_rd(0, 5'd11);
        set_rd(1, 5'd12);
        #1;
        checks++;
        if (rd_busy !== 2'b00) begin failures++; $display("FAIL dual_clr_comb got=%b exp=00", rd_busy); end
        step();
        idle();
        checks++;
        if (pend_cnt !== 6'd1) begin failures++; $display("FAIL dual_clr_after got=%0d exp=1", pend_cnt); end
    endtask

    task automatic test_reset_mid();
        set_rd(0, 5'd4);
        set_rd(1, 5'd7);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if (pend_cnt !== '0 || rd_busy !== '0 || init_done !== 1'b0) begin
            failures++; $display("FAIL midrst pend=%0d busy=%b init=%0b exp 0/00/0", pend_cnt, rd_busy, init_done);
        end
        step();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) step();
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (init_done !== 1'b0 || pend_cnt !== '0) begin
            failures++; $display("FAIL sweep_rst init=%0b pend=%0d exp 0/0", init_done, pend_cnt);
        end
        step();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        for (int i = 0; i < DEPTH; i++) begin
            checks++;
            if (init_done !== 1'b0) begin failures++; $display("FAIL resweep_cycle%0d got=%0b exp=0", i, init_done); end
            step();
        end
        checks++;
        if (init_done !== 1'b1) begin failures++; $display("FAIL resweep_done got=%0b exp=1", init_done); end
        checks++;
        if (rdd(0) !== 32'h0 || rdd(1) !== 32'h0 || pend_cnt !== '0) begin
            failures++; $display("FAIL resweep_clear x4=%h x7=%h pend=%0d exp 0/0/0", rdd(0), rdd(1), pend_cnt);
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        test_reset();
        test_write_read();
        test_bypass();
        test_dual_write();
        test_back_to_back();
        test_scoreboard();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
